// File: rtl/branch_target_buffer.sv
// ==========================================================================
// branch_target_buffer: direct-mapped BTB with saturating direction counters
// Rev 1.0
// ==========================================================================
`default_nettype none

module branch_target_buffer #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_en,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_uncond,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              upd_mispredict,
  input  logic              clr,
  output logic [PERF_W-1:0] perf_hits,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(2 ** (CNT_W - 1));
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_W'(2 ** (CNT_W - 1) - 1);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [ADDR_W-1:0]  target_mem [ENTRIES];
  logic [CNT_W-1:0]   cnt_mem    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  logic             upd_hit;
  logic             upd_we;
  logic             tgt_we;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_nxt;

  // Instruction-alignment bits never take part in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads stored state only, so a same-cycle update is seen next cycle.
  assign lk_hit    = !rst && valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && cnt_mem[lk_idx][CNT_W-1];
  assign lk_target = lk_hit ? target_mem[lk_idx] : '0;

  assign upd_mispredict = !rst && upd_valid &&
                          ((upd_pred_taken != upd_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));

  always_comb begin
    upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    upd_we  = upd_valid && !clr && (upd_hit || upd_taken || upd_uncond);
    tgt_we  = upd_taken || upd_uncond;
    cnt_cur = cnt_mem[upd_idx];
    if (upd_uncond) begin
      cnt_nxt = CNT_MAX;
    end else if (!upd_hit) begin
      cnt_nxt = CNT_WT;
    end else if (upd_taken) begin
      cnt_nxt = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_W'(1);
    end else begin
      cnt_nxt = (cnt_cur == '0) ? cnt_cur : cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        cnt_mem[i]    <= CNT_WNT;
      end
    end else if (clr) begin
      valid <= '0;
    end else if (upd_we) begin
      valid[upd_idx]   <= 1'b1;
      tag_mem[upd_idx] <= upd_tag;
      cnt_mem[upd_idx] <= cnt_nxt;
      if (tgt_we) begin
        target_mem[upd_idx] <= upd_target;
      end
    end
  end

  // Counters survive clr; a dropped update still counts as a mispredict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits    <= '0;
      perf_mispred <= '0;
    end else begin
      if (lk_en && lk_hit && (perf_hits != PERF_MAX)) begin
        perf_hits <= perf_hits + PERF_W'(1);
      end
      if (upd_mispredict && (perf_mispred != PERF_MAX)) begin
        perf_mispred <= perf_mispred + PERF_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
